pixel_sort_seq: RTL and testbench

//  Sequential sorting stage for the image sorting engine: collects a block of N signed
//  16-bit pixel values, sorts them ascending by odd-even transposition, and streams them out.

---
 rtl/pixel_sort_seq_pkg.sv | 13 +
 rtl/pixel_sort_seq_compare16.sv | 19 +
 rtl/pixel_sort_seq.sv | 157 +++++++++++++++
 tb/tb_pixel_sort_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pixel_sort_seq_pkg.sv
// Shared definitions for the pixel sort stage: the FSM state encodings and the
// data width of the compare16 datapath.
package pixel_sort_seq_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SORT   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_sort_seq_compare16.sv
// compare16: signed 16-bit magnitude comparator. Exactly one output is high.
module compare16
  import pixel_sort_seq_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     abigger,
  output logic                     bbigger,
  output logic                     equal
);

  // Both operands are signed, so 0x8000 is the smallest value and 0x7FFF the largest.
  always_comb begin
    abigger = (a > b);
    bbigger = (a < b);
    equal   = (a == b);
  end

endmodule

// File: rtl/pixel_sort_seq.sv
// pixel_sort_seq: loads N signed pixels, sorts them ascending by odd-even
// transposition (one compare-and-swap per clock through compare16), and then
// streams them out smallest first.
// Optional build macro SORT_EARLY_EXIT_EN: SORT ends after two consecutive
// phases that perform no swaps. Without it, SORT always runs all N phases.
module pixel_sort_seq
  import pixel_sort_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int            IW    = $clog2(N);
  localparam logic [IW-1:0] LASTI = IW'(N - 1);

  state_t        state, nxt;
  logic [IW-1:0] load_cnt, unl_cnt, pair, phase;
  logic [W-1:0]  mem [N];

  logic [IW-1:0] pair1;
  logic          abig, bbig, eq, swap;
  logic          accept, pop;
  logic          last_pair, last_phase, sort_done;

  assign pair1  = pair + IW'(1);
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  compare16 u_cmp (
    .a       (mem[pair]),
    .b       (mem[pair1]),
    .abigger (abig),
    .bbigger (bbig),
    .equal   (eq)
  );

  // Swap only on a strict A>B; B>A or equal leaves the pair untouched.
  assign swap = abig && !(bbig || eq);

  // The current pair is the last in its phase when no pair (i+2, i+3) exists.
  assign last_pair = (int'(pair) + 3 >= N);

  // With N=2 the odd phases contain no pairs, so phase 0 is the final phase.
  assign last_phase = (phase == LASTI) || (N < 3 && phase == '0);

`ifdef SORT_EARLY_EXIT_EN
  logic sw_cur, sw_prev, phase_sw, early;
  assign phase_sw  = sw_cur || (swap && state == ST_SORT);
  assign early     = (phase != '0) && !phase_sw && !sw_prev;
  assign sort_done = last_pair && (last_phase || early);
`else
  assign sort_done = last_pair && last_phase;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (accept && load_cnt == LASTI) nxt = ST_SORT;
      end
      ST_SORT: begin
        busy = 1'b1;
        if (sort_done) nxt = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = mem[unl_cnt];
        out_last  = (unl_cnt == LASTI);
        if (pop && unl_cnt == LASTI) nxt = ST_LOAD;
      end
      default: nxt = ST_LOAD;
    endcase
  end

  // Load/pair/phase/unload counters; every wrap is an explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt <= '0;
      unl_cnt  <= '0;
      pair     <= '0;
      phase    <= '0;
`ifdef SORT_EARLY_EXIT_EN
      sw_cur   <= 1'b0;
      sw_prev  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (accept) load_cnt <= (load_cnt == LASTI) ? '0 : load_cnt + IW'(1);
        end
        ST_SORT: begin
          if (sort_done) begin
            pair  <= '0;
            phase <= '0;
          end else if (last_pair) begin
            // Next phase starts at pair 0 when even, pair 1 when odd.
            pair     <= '0;
            pair[0]  <= ~phase[0];
            phase    <= phase + IW'(1);
          end else begin
            pair <= pair + IW'(2);
          end
`ifdef SORT_EARLY_EXIT_EN
          if (sort_done) begin
            sw_cur  <= 1'b0;
            sw_prev <= 1'b0;
          end else if (last_pair) begin
            sw_prev <= phase_sw;
            sw_cur  <= 1'b0;
          end else begin
            sw_cur  <= phase_sw;
          end
`endif
        end
        ST_UNLOAD: begin
          if (pop) unl_cnt <= (unl_cnt == LASTI) ? '0 : unl_cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Word storage: written on load and on a swap. Not reset, since it is never
  // read before a full block has been loaded.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && accept) mem[load_cnt] <= in_data;
    if (state == ST_SORT && swap) begin
      mem[pair]  <= mem[pair1];
      mem[pair1] <= mem[pair];
    end
  end

endmodule

// File: tb/tb_pixel_sort_seq.sv
// Directed bench for pixel_sort_seq (N=8): reset behaviour, sort order with
// signed data, SORT latency, output back-pressure and reset during SORT.
module tb_pixel_sort_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] vin [8];
  logic [15:0] vexp[8];

`ifdef SORT_EARLY_EXIT_EN
  localparam int EQ_BUSY = 7;
`else
  localparam int EQ_BUSY = 28;
`endif

  pixel_sort_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present vin[0..7]; returns #1 after the edge that accepted the 8th word.
  task automatic load_block();
    for (int i = 0; i < 8; i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = vin[i];
      while (!in_ready && t < 100) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 100) chk("load_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Count SORT cycles; exp_busy < 0 skips the latency check.
  task automatic count_busy(input string tag, input int exp_busy);
    int n = 0;
    while (busy && n < 200) begin
      if (in_ready) chk({tag, "_inready_in_sort"}, 32'(in_ready), 0);
      n++;
      @(posedge clk); #1;
    end
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
  endtask

  // Drain 8 words against vexp; stall_at >= 0 drops out_ready for 5 cycles
  // before that output index.
  task automatic unload_block(input string tag, input int stall_at);
    for (int k = 0; k < 8; k++) begin
      int t = 0;
      out_ready = 1'b1;
      while (!out_valid && t < 100) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 100) chk({tag, "_out_timeout"}, 0, 1);
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          chk({tag, "_stall_data"}, 32'(out_data), 32'(vexp[k]));
          chk({tag, "_stall_valid"}, 32'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s_data%0d", tag, k), 32'(out_data), 32'(vexp[k]));
      chk($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == 7));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk({tag, "_back_to_load"}, 32'({in_ready, out_valid, busy}), 32'b100);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'({in_ready, out_valid, busy, out_last}), 32'b1000);
    chk("rst_data", 32'(out_data), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reversed block: full 28-cycle sort.
    for (int i = 0; i < 8; i++) begin vin[i] = 16'(7 - i); vexp[i] = 16'(i); end
    load_block();
    count_busy("rev", 28);
    unload_block("rev", -1);

    // Signed extremes.
    vin  = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 16'h0100, 16'h8001};
    vexp = '{16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0100, 16'h7FFF};
    load_block();
    count_busy("sgn", -1);
    unload_block("sgn", -1);

    // All equal: no swaps.
    for (int i = 0; i < 8; i++) begin vin[i] = 16'h0040; vexp[i] = 16'h0040; end
    load_block();
    count_busy("eq", EQ_BUSY);
    unload_block("eq", -1);

    // Back-pressure after the third output.
    vin  = '{16'd3, 16'd1, 16'd2, 16'd0, 16'd7, 16'd5, 16'd6, 16'd4};
    for (int i = 0; i < 8; i++) vexp[i] = 16'(i);
    load_block();
    count_busy("stall", -1);
    unload_block("stall", 3);

    // Reset while UNLOAD is presenting data: outputs drop immediately.
    load_block();
    count_busy("rstu", -1);
    chk("rstu_valid_pre", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstu_state", 32'({in_ready, out_valid, busy, out_last}), 32'b1000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset at SORT cycle 10, then a clean full run.
    for (int i = 0; i < 8; i++) begin vin[i] = 16'(8 - i); vexp[i] = 16'(i + 1); end
    load_block();
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    chk("rsts_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rsts_state", 32'({in_ready, out_valid, busy, out_last}), 32'b1000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    load_block();
    count_busy("rsts", 28);
    unload_block("rsts", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
